yuv_framestore_writer: RTL and testbench

- Consumes the reconstructed 8-bit pixel stream from the picture decoder: YUV samples, write enable and a start/idle flag.
- Samples arrive in macroblock/block order: 6 blocks per macroblock (Y0 top-left, Y1 top-right, Y2 bottom-left, Y3 bottom-right, Cb, Cr), each 8x8 in row-major order.
- Packs 4 horizontally adjacent pixels into one 32-bit word and computes the raster-order 19-bit word address in a planar 4:2:0 framestore.
- Writes words through a small FIFO to the framestore port, which uses a busy handshake.

---
 rtl/yuv_framestore_writer_pkg.sv | 27 ++
 rtl/yuv_word_fifo.sv | 66 ++++++
 rtl/yuv_framestore_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_yuv_framestore_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yuv_framestore_writer_pkg.sv
// ----------------------------------------------------------------------------
// yuv_framestore_writer_pkg
//   Shared constants and types for the YUV framestore writer:
//   - writer FSM state encoding
//   - macroblock geometry constants
//   - the {address,data} word carried through the write FIFO
// ----------------------------------------------------------------------------
package yuv_framestore_writer_pkg;

    localparam int BLOCKS_PER_MACROBLOCK = 6;  // Y0..Y3, Cb, Cr
    localparam int FS_PIXELS_PER_WORD    = 4;  // 8-bit pixels packed per 32-bit word
    localparam int FS_ADDR_W             = 19;
    localparam int FS_DATA_W             = 32;

    typedef enum logic [1:0] {
        FS_WRITER_IDLE  = 2'd0,
        FS_WRITER_FRAME = 2'd1,
        FS_WRITER_DRAIN = 2'd2
    } fs_writer_state_e;

    // One framestore write: 19-bit word address + 32-bit data = 51 bits.
    typedef struct packed {
        logic [FS_ADDR_W-1:0] addr;
        logic [FS_DATA_W-1:0] data;
    } fs_word_t;

endpackage

// File: rtl/yuv_word_fifo.sv
// ----------------------------------------------------------------------------
// yuv_word_fifo
//   Synchronous FIFO of {address,data} words toward the framestore.
//   A push while full succeeds only if a pop happens in the same cycle.
// Ports:
//   clock, resetn   clock / asynchronous active-low reset
//   push_i          write push_word_i this cycle
//   push_word_i     {address,data} entry
//   pop_i           consume the head entry (ignored when empty)
//   head_o          oldest entry
//   full_o/empty_o  occupancy flags
// ----------------------------------------------------------------------------
module yuv_word_fifo
    import yuv_framestore_writer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clock,
    input  logic     resetn,
    input  logic     push_i,
    input  fs_word_t push_word_i,
    input  logic     pop_i,
    output fs_word_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fs_word_t         mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: storage is not reset; the pointers alone define which entries are
    // valid, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign head_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/yuv_framestore_writer.sv
// ----------------------------------------------------------------------------
// yuv_framestore_writer
//   Takes the decoder's reconstructed pixel stream (macroblock / 8x8 block
//   order), packs 4 horizontal pixels per 32-bit word, computes the raster
//   word address in a planar 4:2:0 framestore and queues writes in a FIFO.
// Ports:
//   clock, resetn             clock / asynchronous active-low reset
//   YUV_Data_I/_Write_En_I    pixel and its valid
//   YUV_Start_I               high = idle; falling edge starts a frame,
//                             rising edge mid-frame aborts it
//   Image_Horizontal/Vertical picture size in pixels (multiples of 16)
//   Frame_Base_I              frame buffer word offset, latched at start
//   Framestore_*              write port (busy handshake, FIFO-backed)
//   Frame_Done_O              pulse once the frame is fully written
//   Overflow_O                sticky: a word was dropped (FIFO full)
// ----------------------------------------------------------------------------
module yuv_framestore_writer
    import yuv_framestore_writer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [18:0] Y_BASE     = 19'h00000,
    parameter logic [18:0] CB_BASE    = 19'h20000,
    parameter logic [18:0] CR_BASE    = 19'h28000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  YUV_Data_I,
    input  logic        YUV_Write_En_I,
    input  logic        YUV_Start_I,
    input  logic [11:0] Image_Horizontal_I,
    input  logic [11:0] Image_Vertical_I,
    input  logic [18:0] Frame_Base_I,
    output logic [18:0] Framestore_Address_O,
    output logic [31:0] Framestore_Data_O,
    output logic        Framestore_Write_En_O,
    input  logic        Framestore_Busy_I,
    output logic        Framestore_Active_O,
    output logic        Frame_Done_O,
    output logic        Overflow_O
);

    fs_writer_state_e state_q, state_d;
    logic             start_q;
    logic [18:0]      base_q, base_d;
    logic [5:0]       pix_q, pix_d;
    logic [2:0]       blk_q, blk_d;
    logic [5:0]       mb_col_q, mb_col_d;
    logic [4:0]       mb_row_q, mb_row_d;
    logic [23:0]      pack_q, pack_d;
    logic             overflow_q, overflow_d;

    logic             s1_valid_q;
    logic [18:0]      s1_prod_q, s1_plane_q;
    logic [7:0]       s1_col_q;
    logic [31:0]      s1_data_q;
    logic             s2_valid_q;
    fs_word_t         s2_word_q;

    logic             fifo_full, fifo_empty, fifo_pop, fifo_drop;
    fs_word_t         fifo_head;

    // Size bits outside the supported ranges are not needed.
    logic unused_size_bits;
    assign unused_size_bits = ^{Image_Horizontal_I[1:0], Image_Vertical_I[11:9],
                                Image_Vertical_I[3:0]};

    // ---------------- control decode ----------------
    logic in_frame, frame_start, abort, accept, word_done, last_pixel, drained;
    logic pix_wrap, blk_wrap, col_wrap, row_wrap;

    assign in_frame    = (state_q == FS_WRITER_FRAME);
    assign frame_start = (state_q == FS_WRITER_IDLE) & start_q & ~YUV_Start_I;
    assign abort       = in_frame & YUV_Start_I & ~start_q;
    assign accept      = in_frame & YUV_Write_En_I & ~abort;
    assign pix_wrap    = (pix_q == 6'd63);
    assign blk_wrap    = (blk_q == 3'(BLOCKS_PER_MACROBLOCK - 1));
    assign col_wrap    = (mb_col_q == Image_Horizontal_I[9:4] - 6'd1);
    assign row_wrap    = (mb_row_q == Image_Vertical_I[8:4] - 5'd1);
    assign word_done   = accept & (pix_q[1:0] == 2'(FS_PIXELS_PER_WORD - 1));
    assign last_pixel  = accept & pix_wrap & blk_wrap & col_wrap & row_wrap;
    assign drained     = ~s1_valid_q & ~s2_valid_q & fifo_empty;

    // ---------------- address operands for the completing word ----------------
    logic [8:0]  py;
    logic [9:0]  stride;
    logic [7:0]  col_w;
    logic [18:0] plane;
    logic [18:0] prod;

    // NOTE: every signal assigned in a combinational block gets a default
    // (or an assignment on every path) so no latch is inferred.
    always_comb begin
        if (blk_q[2]) begin
            // Chroma: half-resolution plane, its own stride.
            py     = {1'b0, mb_row_q, pix_q[5:3]};
            stride = {1'b0, Image_Horizontal_I[11:3]};
            col_w  = {1'b0, mb_col_q, pix_q[2]};
            plane  = blk_q[0] ? CR_BASE : CB_BASE;
        end else begin
            py     = {mb_row_q, blk_q[1], pix_q[5:3]};
            stride = Image_Horizontal_I[11:2];
            col_w  = {mb_col_q, blk_q[0], pix_q[2]};
            plane  = Y_BASE;
        end
        prod = 19'({10'd0, py} * {9'd0, stride});
    end

    // ---------------- counters, pack register, overflow ----------------
    always_comb begin
        base_d     = base_q;
        pix_d      = pix_q;
        blk_d      = blk_q;
        mb_col_d   = mb_col_q;
        mb_row_d   = mb_row_q;
        pack_d     = pack_q;
        overflow_d = overflow_q | fifo_drop;
        if (frame_start) begin
            base_d     = Frame_Base_I;
            pix_d      = '0;
            blk_d      = '0;
            mb_col_d   = '0;
            mb_row_d   = '0;
            pack_d     = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            pack_d = {pack_q[15:0], YUV_Data_I};
            pix_d  = pix_q + 6'd1;
            if (pix_wrap) begin
                blk_d = blk_wrap ? 3'd0 : blk_q + 3'd1;
                if (blk_wrap) begin
                    mb_col_d = col_wrap ? 6'd0 : mb_col_q + 6'd1;
                    if (col_wrap) mb_row_d = row_wrap ? 5'd0 : mb_row_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            start_q    <= 1'b0;
            base_q     <= '0;
            pix_q      <= '0;
            blk_q      <= '0;
            mb_col_q   <= '0;
            mb_row_q   <= '0;
            pack_q     <= '0;
            overflow_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_plane_q <= '0;
            s1_col_q   <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
        end else begin
            start_q    <= YUV_Start_I;
            base_q     <= base_d;
            pix_q      <= pix_d;
            blk_q      <= blk_d;
            mb_col_q   <= mb_col_d;
            mb_row_q   <= mb_row_d;
            pack_q     <= pack_d;
            overflow_q <= overflow_d;
            // Stage 1: operands and py*stride.
            s1_valid_q <= word_done;
            if (word_done) begin
                s1_prod_q  <= prod;
                s1_plane_q <= plane;
                s1_col_q   <= col_w;
                s1_data_q  <= {pack_q, YUV_Data_I};
            end
            // Stage 2: add frame base, plane offset, row product and column.
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_word_q.addr <= base_q + s1_plane_q + s1_prod_q + {11'd0, s1_col_q};
                s2_word_q.data <= s1_data_q;
            end
        end
    end

    // ---------------- stage 3: FIFO ----------------
    assign fifo_pop  = ~fifo_empty & ~Framestore_Busy_I;
    assign fifo_drop = s2_valid_q & fifo_full & ~fifo_pop;

    yuv_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .push_i      (s2_valid_q),
        .push_word_i (s2_word_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ---------------- writer FSM ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= FS_WRITER_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_WRITER_IDLE:  if (frame_start)         state_d = FS_WRITER_FRAME;
            FS_WRITER_FRAME: if (abort || last_pixel) state_d = FS_WRITER_DRAIN;
            FS_WRITER_DRAIN: if (drained)             state_d = FS_WRITER_IDLE;
            default:                                  state_d = FS_WRITER_IDLE;
        endcase
    end

    always_comb begin
        Frame_Done_O = (state_q == FS_WRITER_DRAIN) & drained;
    end

    // Head is masked while empty so the port reads zero instead of stale RAM.
    assign Framestore_Active_O   = ~fifo_empty;
    assign Framestore_Write_En_O = fifo_pop;
    assign Framestore_Address_O  = fifo_empty ? 19'd0 : fifo_head.addr;
    assign Framestore_Data_O     = fifo_empty ? 32'd0 : fifo_head.data;
    assign Overflow_O            = overflow_q;

endmodule

// File: tb/tb_yuv_framestore_writer.sv
// ----------------------------------------------------------------------------
// tb_yuv_framestore_writer
//   Directed bench for yuv_framestore_writer on a 32x16 picture. Pixel i of a
//   frame carries the value (i+16) mod 256; written words are captured in
//   order and compared against hand-computed and model addresses.
// ----------------------------------------------------------------------------
module tb_yuv_framestore_writer;

    logic        clock;
    logic        resetn;
    logic [7:0]  YUV_Data_I;
    logic        YUV_Write_En_I;
    logic        YUV_Start_I;
    logic [11:0] Image_Horizontal_I;
    logic [11:0] Image_Vertical_I;
    logic [18:0] Frame_Base_I;
    logic [18:0] Framestore_Address_O;
    logic [31:0] Framestore_Data_O;
    logic        Framestore_Write_En_O;
    logic        Framestore_Busy_I;
    logic        Framestore_Active_O;
    logic        Frame_Done_O;
    logic        Overflow_O;

    yuv_framestore_writer dut (
        .clock                 (clock),
        .resetn                (resetn),
        .YUV_Data_I            (YUV_Data_I),
        .YUV_Write_En_I        (YUV_Write_En_I),
        .YUV_Start_I           (YUV_Start_I),
        .Image_Horizontal_I    (Image_Horizontal_I),
        .Image_Vertical_I      (Image_Vertical_I),
        .Frame_Base_I          (Frame_Base_I),
        .Framestore_Address_O  (Framestore_Address_O),
        .Framestore_Data_O     (Framestore_Data_O),
        .Framestore_Write_En_O (Framestore_Write_En_O),
        .Framestore_Busy_I     (Framestore_Busy_I),
        .Framestore_Active_O   (Framestore_Active_O),
        .Frame_Done_O          (Frame_Done_O),
        .Overflow_O            (Overflow_O)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec;
    int          n_err;
    int          wr_cnt;
    int          done_cnt;
    logic [50:0] wq[$];

    // Capture every consumed word and every done pulse, mid-cycle.
    always @(negedge clock) begin
        if (Framestore_Write_En_O) begin
            wq.push_back({Framestore_Address_O, Framestore_Data_O});
            wr_cnt++;
        end
        if (Frame_Done_O) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input logic [18:0] base);
        YUV_Start_I  = 1'b1;
        Frame_Base_I = base;
        tick();
        tick();
        YUV_Start_I = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_pixels(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            YUV_Data_I     = 8'(first + i + 16);
            YUV_Write_En_I = 1'b1;
            tick();
        end
        YUV_Write_En_I = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        check(tag, done_cnt - d0, 1);
    endtask

    // Expected address of word k of a frame of width w (pixels), from the
    // raster formulas for a planar 4:2:0 store.
    function automatic logic [18:0] model_addr(input int k, input int w, input logic [18:0] base);
        int p, mb, blk, pix, mbc, mbr, row, half, px, py, stride;
        logic [18:0] plane;
        p    = 4 * k;
        mb   = p / 384;
        blk  = (p % 384) / 64;
        pix  = p % 64;
        mbc  = mb % (w / 16);
        mbr  = mb / (w / 16);
        row  = pix / 8;
        half = (pix / 4) % 2;
        if (blk < 4) begin
            px = mbc * 16 + (blk % 2) * 8 + half * 4;
            py = mbr * 16 + (blk / 2) * 8 + row;
            stride = w / 4;
            plane = 19'h00000;
        end else begin
            px = mbc * 8 + half * 4;
            py = mbr * 8 + row;
            stride = w / 8;
            plane = (blk == 4) ? 19'h20000 : 19'h28000;
        end
        return 19'(base + plane + 19'(py * stride + px / 4));
    endfunction

    function automatic logic [31:0] model_data(input int k);
        return {8'(4 * k + 16), 8'(4 * k + 17), 8'(4 * k + 18), 8'(4 * k + 19)};
    endfunction

    function automatic logic [50:0] entry(input int i);
        if (i < wq.size()) return wq[i];
        return '1;
    endfunction

    int prior_done;

    initial begin
        n_vec = 0; n_err = 0; wr_cnt = 0; done_cnt = 0;
        resetn             = 1'b0;
        YUV_Data_I         = 8'd0;
        YUV_Write_En_I     = 1'b0;
        YUV_Start_I        = 1'b1;
        Image_Horizontal_I = 12'd32;
        Image_Vertical_I   = 12'd16;
        Frame_Base_I       = 19'd0;
        Framestore_Busy_I  = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_active",   Framestore_Active_O,   0);
        check("rst_we",       Framestore_Write_En_O, 0);
        check("rst_addr",     Framestore_Address_O,  0);
        check("rst_done",     Frame_Done_O,          0);
        check("rst_overflow", Overflow_O,            0);
        resetn = 1'b1;
        tick();

        // Full 32x16 frame at base 0.
        wq.delete();
        wr_cnt = 0;
        start_frame(19'h00000);
        send_pixels(0, 768);
        wait_done("frame0_done", 200);
        check("frame0_writes",   wr_cnt,     192);
        check("frame0_overflow", Overflow_O, 0);
        check("blk0_w0",   entry(0),       {19'h00000, 32'h10111213});
        check("blk0_p8",   entry(2) >> 32, 19'h00008);
        check("blk1_p0",   entry(16) >> 32, 19'h00002);
        check("blk2_p0",   entry(32) >> 32, 19'h00040);
        check("cb_mb0",    entry(64) >> 32, 19'h20000);
        check("cb_mb1",    entry(160) >> 32, 19'h20002);
        check("cr_mb0_p8", entry(82),      {19'h28004, 32'h58595a5b});
        for (int k = 0; k < 192 && k < wq.size(); k++)
            check($sformatf("frame0_w%0d", k), wq[k], {model_addr(k, 32, 19'h0), model_data(k)});

        // Same frame at base 0x40000.
        wq.delete();
        wr_cnt = 0;
        start_frame(19'h40000);
        send_pixels(0, 768);
        wait_done("frame1_done", 200);
        check("frame1_writes", wr_cnt,          192);
        check("b_blk0_w0",     entry(0) >> 32,  19'h40000);
        check("b_cb_mb0",      entry(64) >> 32, 19'h60000);
        check("b_cb_mb1",      entry(160) >> 32, 19'h60002);
        check("b_cr_mb0_p8",   entry(82) >> 32, 19'h68004);

        // Busy for 80 input cycles: 20 words into a 16-deep FIFO.
        start_frame(19'h00000);
        Framestore_Busy_I = 1'b1;
        send_pixels(0, 80);
        for (int i = 0; i < 5; i++) tick();
        check("busy_overflow", Overflow_O,          1);
        check("busy_active",   Framestore_Active_O, 1);
        wq.delete();
        Framestore_Busy_I = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("busy_count", wq.size(), 16);
        for (int k = 0; k < 16 && k < wq.size(); k++)
            check($sformatf("busy_w%0d", k), wq[k], {model_addr(k, 32, 19'h0), model_data(k)});
        YUV_Start_I = 1'b1;
        wait_done("busy_abort_done", 50);
        check("overflow_held", Overflow_O, 1);

        // Abort after pixel 2 of the second word; the pixel during the rising
        // edge cycle must not complete that word.
        wq.delete();
        start_frame(19'h00000);
        check("overflow_cleared", Overflow_O, 0);
        send_pixels(0, 7);
        YUV_Data_I     = 8'h17;
        YUV_Write_En_I = 1'b1;
        YUV_Start_I    = 1'b1;
        tick();
        YUV_Write_En_I = 1'b0;
        wait_done("abort_done", 50);
        check("abort_count", wq.size(), 1);
        check("abort_w0",    entry(0),  {19'h00000, 32'h10111213});

        // Reset mid-frame with words pending.
        start_frame(19'h00000);
        Framestore_Busy_I = 1'b1;
        send_pixels(0, 8);
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_active", Framestore_Active_O, 1);
        prior_done = done_cnt;
        resetn = 1'b0;
        tick();
        check("mrst_active", Framestore_Active_O,   0);
        check("mrst_we",     Framestore_Write_En_O, 0);
        check("mrst_addr",   Framestore_Address_O,  0);
        check("mrst_data",   Framestore_Data_O,     0);
        check("mrst_done",   Frame_Done_O,          0);
        Framestore_Busy_I = 1'b0;
        resetn = 1'b1;
        tick();
        tick();
        check("mrst_no_done_pulse", done_cnt, prior_done);
        wq.delete();
        start_frame(19'h00100);
        send_pixels(0, 4);
        for (int i = 0; i < 6; i++) tick();
        check("restart_count", wq.size(), 1);
        check("restart_w0",    entry(0),  {19'h00100, 32'h10111213});
        YUV_Start_I = 1'b1;
        wait_done("restart_abort_done", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
